rv_mul_seq: RTL

Sequencer for the multicycle core's byte-serial multiplier datapath (MUL, low 32 bits of the product).
- On a start request from the main control FSM, it clears the product register.
- It then steps through every byte-pair partial product that contributes to bits [31:0], driving Ma_sel, Mb_sel, Mshift_val and Mupd_prod.
- It pulses done when the product is complete.
- The main FSM holds the instruction in its execute state while busy is high.

---
 rtl/rv_mul_pkg.sv | 45 ++++
 rtl/rv_mul_next_pair.sv | 32 +++
 rtl/rv_mul_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/rv_mul_pkg.sv
// rtl/rv_mul_pkg.sv - shared types and byte-pair table for the sequential multiplier
package rv_mul_pkg;

   localparam int NPAIRS = 10;
   localparam int IDXW   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Pairs are ordered by A byte, then B byte; only pairs with i+j <= 3 reach bits [31:0].
   function automatic logic [1:0] pair_a(input logic [IDXW-1:0] idx);
      case (idx)
         4'd0, 4'd1, 4'd2, 4'd3: pair_a = 2'd0;
         4'd4, 4'd5, 4'd6:       pair_a = 2'd1;
         4'd7, 4'd8:             pair_a = 2'd2;
         4'd9:                   pair_a = 2'd3;
         default:                pair_a = 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] pair_b(input logic [IDXW-1:0] idx);
      case (idx)
         4'd0, 4'd4, 4'd7, 4'd9: pair_b = 2'd0;
         4'd1, 4'd5, 4'd8:       pair_b = 2'd1;
         4'd2, 4'd6:             pair_b = 2'd2;
         4'd3:                   pair_b = 2'd3;
         default:                pair_b = 2'd0;
      endcase
   endfunction

   function automatic logic [4:0] pair_shift(input logic [IDXW-1:0] idx);
      case (idx)
         4'd0:                   pair_shift = 5'd0;
         4'd1, 4'd4:             pair_shift = 5'd8;
         4'd2, 4'd5, 4'd7:       pair_shift = 5'd16;
         4'd3, 4'd6, 4'd8, 4'd9: pair_shift = 5'd24;
         default:                pair_shift = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/rv_mul_next_pair.sv
// rtl/rv_mul_next_pair.sv - priority search for the next enabled byte pair
module rv_mul_next_pair
   import rv_mul_pkg::*;
(
   input  logic [3:0]      amask,
   input  logic [3:0]      bmask,
   input  logic [IDXW-1:0] cur_idx,
   input  logic            from_start,
   output logic [IDXW-1:0] next_idx,
   output logic            found
);

   logic [NPAIRS-1:0] cand;

   always_comb begin
      cand = '0;
      for (int k = 0; k < NPAIRS; k++) begin
         cand[k] = amask[pair_a(IDXW'(k))] & bmask[pair_b(IDXW'(k))]
                   & (from_start | (IDXW'(k) > cur_idx));
      end
      next_idx = '0;
      found    = 1'b0;
      // Descending scan so the lowest candidate wins.
      for (int k = NPAIRS - 1; k >= 0; k--) begin
         if (cand[k]) begin
            next_idx = IDXW'(k);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rv_mul_seq.sv
// rtl/rv_mul_seq.sv - control sequencer for the byte-serial MUL datapath
module rv_mul_seq
   import rv_mul_pkg::*;
#(
   parameter int DPWIDTH   = 32,
   parameter bit SKIP_ZERO = 1'b1
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DPWIDTH/8-1:0] a_nz,
   input  logic [DPWIDTH/8-1:0] b_nz,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           Ma_sel,
   output logic [1:0]           Mb_sel,
   output logic [4:0]           Mshift_val,
   output logic                 Mupd_prod,
   output logic                 Mclr_prod
);

   localparam int NLANES = DPWIDTH / 8;

   state_t            state, state_nxt;
   logic [NLANES-1:0] amask, amask_nxt;
   logic [NLANES-1:0] bmask, bmask_nxt;
   logic [IDXW-1:0]   idx, idx_nxt;
   logic [IDXW-1:0]   np_idx;
   logic              np_found;

   rv_mul_next_pair u_next_pair (
      .amask      (amask),
      .bmask      (bmask),
      .cur_idx    (idx),
      .from_start (state == CLR),
      .next_idx   (np_idx),
      .found      (np_found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         amask <= '0;
         bmask <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         amask <= amask_nxt;
         bmask <= bmask_nxt;
         idx   <= idx_nxt;
      end
   end

   // Outputs decode straight from registered state so an async reset clears them at once.
   always_comb begin
      state_nxt  = state;
      amask_nxt  = amask;
      bmask_nxt  = bmask;
      idx_nxt    = idx;
      busy       = 1'b0;
      done       = 1'b0;
      Ma_sel     = 2'd0;
      Mb_sel     = 2'd0;
      Mshift_val = 5'd0;
      Mupd_prod  = 1'b0;
      Mclr_prod  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               amask_nxt = SKIP_ZERO ? a_nz : {NLANES{1'b1}};
               bmask_nxt = SKIP_ZERO ? b_nz : {NLANES{1'b1}};
               state_nxt = CLR;
            end
         end
         CLR: begin
            busy      = 1'b1;
            Mclr_prod = 1'b1;
            if (np_found) begin
               idx_nxt   = np_idx;
               state_nxt = ACC;
            end else begin
               state_nxt = DONE;
            end
         end
         ACC: begin
            busy       = 1'b1;
            Mupd_prod  = 1'b1;
            Ma_sel     = pair_a(idx);
            Mb_sel     = pair_b(idx);
            Mshift_val = pair_shift(idx);
            if (np_found) begin
               idx_nxt = np_idx;
            end else begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            idx_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
